deserializer_fifo: RTL

//  Parametrised serial-to-parallel converter. Collects DATA_W serial bits strobed by write_in.

---
 rtl/deser_pkg.sv | 10 +
 rtl/sync_word_fifo.sv | 50 +++++
 rtl/deserializer_fifo.sv | 119 +++++++++++
 3 files changed

// File: rtl/deser_pkg.sv
// Shared types and helpers for the serial-to-parallel deserializer.
package deser_pkg;

  typedef enum logic [0:0] {S_COLLECT = 1'b0, S_HOLD = 1'b1} deser_state_t;

  function automatic int unsigned bit_cnt_w(input int unsigned data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/sync_word_fifo.sv
// Single-clock word FIFO; accepts a push while full if a pop happens on the same edge.
module sync_word_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk_100KHz,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          head,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == CNT_W'(0));
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_100KHz or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      // Simultaneous push and pop leave the occupancy unchanged
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/deserializer_fifo.sv
// Serial-to-parallel converter: shifts strobed bits into words and queues them for a
// data_ready/ack_in consumer, holding the last word while the queue is full.
module deserializer_fifo
  import deser_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                       clk_100KHz,
  input  logic                       reset,
  input  logic                       data_in,
  input  logic                       write_in,
  input  logic                       ack_in,
  output logic                       status_out,
  output logic [DATA_W-1:0]          data_out,
  output logic                       data_ready,
  output logic [$clog2(DEPTH+1)-1:0] count_out,
  output logic                       overflow_out
);

  localparam int unsigned CW = bit_cnt_w(DATA_W);

  deser_state_t      state;
  deser_state_t      state_next;
  logic [DATA_W-1:0] shifter;
  logic [DATA_W-1:0] shifter_next;
  logic [DATA_W-1:0] shift_in;
  logic [CW-1:0]     bit_cnt;
  logic [CW-1:0]     cnt_next;
  logic              overflow;
  logic              ovf_next;
  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              pop;
  logic              space;
  logic [DATA_W-1:0] head;
  logic              empty;
  logic              full;

  assign shift_in = MSB_FIRST ? {shifter[DATA_W-2:0], data_in}
                              : {data_in, shifter[DATA_W-1:1]};

  assign pop   = ack_in & ~empty;
  assign space = ~full | pop;

  always_ff @(posedge clk_100KHz or posedge reset) begin
    if (reset) begin
      state    <= S_COLLECT;
      shifter  <= '0;
      bit_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      shifter  <= shifter_next;
      bit_cnt  <= cnt_next;
      overflow <= ovf_next;
    end
  end

  always_comb begin
    state_next   = state;
    shifter_next = shifter;
    cnt_next     = bit_cnt;
    ovf_next     = overflow;
    push         = 1'b0;
    push_data    = shifter;
    case (state)
      S_COLLECT: begin
        if (write_in) begin
          shifter_next = shift_in;
          if (bit_cnt == CW'(DATA_W - 1)) begin
            if (space) begin
              push      = 1'b1;
              push_data = shift_in;
              cnt_next  = '0;
            end else begin
              cnt_next   = CW'(DATA_W);
              state_next = S_HOLD;
            end
          end else begin
            cnt_next = bit_cnt + CW'(1);
          end
        end
      end
      S_HOLD: begin
        // Serial side is stalled: any strobe here loses a bit
        if (write_in) ovf_next = 1'b1;
        if (space) begin
          push       = 1'b1;
          cnt_next   = '0;
          state_next = S_COLLECT;
        end
      end
      default: state_next = S_COLLECT;
    endcase
  end

  sync_word_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_100KHz(clk_100KHz),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .empty     (empty),
    .full      (full),
    .count     (count_out)
  );

  assign status_out   = (state == S_COLLECT);
  assign data_ready   = ~empty;
  assign data_out     = empty ? '0 : head;
  assign overflow_out = overflow;

endmodule
